pio_gen_edge: RTL
=================

Name: pio_gen_edge

Overview:
- Parametrised general-purpose I/O slave on the Avalon-MM bus of the JTAG debug system.
- Next generation of the single-bit output PIO: WIDTH bits, per-bit direction control, atomic set/clear of output bits, synchronised input sampling, per-bit edge capture and a maskable level interrupt.
- Sits beside the other debug-system PIOs; drives core control lines and samples status lines from the core.

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- OUT_RESET, 0, reset value of the output data register (WIDTH bits).
- DIR_RESET, 0, reset value of the direction register; 1 = output, 0 = input.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- read_n  in  1  active-low read strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH-1 are ignored.
- readdata  out  32  registered read data, fixed read latency of 1.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  direction register; 1 = drive the bit.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - out_port=OUT_RESET, oe=DIR_RESET, irq_mask=0, edge_capture=0.
  - All synchroniser stages and the previous-sample register are cleared to 0.
  - irq=0, readdata=0.
  - Reset overrides any concurrent bus access.
- Register map (wr = chipselect & ~write_n; rd = chipselect & ~read_n):
  - 0 DATA. Read: bit i = oe[i] ? out_port[i] : sync_in[i]. Write: out_port <= writedata[WIDTH-1:0].
  - 1 DIR. Read/write oe.
  - 2 IRQMASK. Read/write irq_mask.
  - 3 EDGE. Read edge_capture. Write-1-to-clear per bit.
  - 4 OUTSET. out_port <= out_port | wdata. Reads 0.
  - 5 OUTCLR. out_port <= out_port & ~wdata. Reads 0.
  - 6, 7: writes ignored, reads 0.
- Writes take effect at the clk edge where wr is high.
- If rd and wr are both asserted in one cycle, the write is performed and the read returns the pre-write value.
- Read timing:
  - readdata is loaded at the edge where rd=1 and holds its value otherwise.
  - Bits 31..WIDTH are always 0.
- Input path:
  - 2-flop synchroniser in_port -> s1 -> s2, where sync_in=s2.
  - prev register samples s2 each cycle.
  - rise = s2 & ~prev; fall = ~s2 & prev; the edge term is selected by EDGE_TYPE.
- Edge capture:
  - edge_capture[i] sets when edge[i] & ~oe[i] (inputs only).
  - A bit stays set until cleared by a write of 1 to EDGE.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Latency: an in_port change sampled at edge k gives s2 valid after k+1, edge_capture set after k+2, irq high after k+3.
- irq:
  - irq <= |(edge_capture & irq_mask), registered.
  - Unmasking an already-captured bit raises irq one cycle after the mask write.
  - Clearing edge_capture drops irq one cycle after the clear.
- Direction changes:
  - A bit switched from output to input does not generate a spurious capture, because prev tracks s2 continuously.
  - Bits switched to output stop capturing immediately.

Test Plan:
1. Reset with WIDTH=8, OUT_RESET=8'hA5, DIR_RESET=8'hFF -> out_port=A5, oe=FF, irq=0; a read of addr 0 returns 32'h000000A5 one cycle later.
2. Write DATA=0x0F, then OUTSET=0x30, then OUTCLR=0x05 -> out_port goes 0F, 3F, 3A on consecutive cycles; a read of addr 4 returns 0.
3. oe=0, mask=0x01, EDGE_TYPE=0, in_port[0] rises -> edge_capture=0x01 two cycles after the sampling edge, irq=1 one cycle later; W1C 0x01 to EDGE -> irq=0 next cycle.
4. Same-cycle W1C of bit 0 and a new rising edge on bit 0 -> edge_capture[0] remains 1 and irq stays high.
5. EDGE_TYPE=2, with a 1-cycle pulse on in_port[3] and oe[3]=1 -> no capture; with oe[3]=0 -> edge_capture[3]=1; mask=0 keeps irq=0 until mask=0x08 is written, then irq=1 next cycle.
6. Assert reset during a pending irq and a mid-transfer read -> irq, edge_capture and readdata are 0 at the next edge; the bus write in that cycle is ignored.

Source files
------------

// File: rtl/pio_gen_edge.sv
// ---------------------------------------------------------------------------
// pio_gen_edge -- parametrised general-purpose I/O slave (Avalon-MM).
//
// WIDTH bits of I/O with per-bit direction, atomic set/clear of output bits,
// two-flop input synchronisation, per-bit edge capture (write-1-to-clear)
// and a maskable, registered level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   read_n     active-low read strobe, qualified by chipselect
//   writedata  write data, bits above WIDTH-1 ignored
//   readdata   registered read data, read latency 1
//   in_port    asynchronous external inputs
//   out_port   output data register
//   oe         direction register, 1 = drive the bit
//   irq        registered level interrupt
//
// Register map:
//   0 DATA     rd: oe ? out_port : synchronised input   wr: out_port
//   1 DIR      rd/wr oe
//   2 IRQMASK  rd/wr irq mask
//   3 EDGE     rd edge capture, wr 1 to clear
//   4 OUTSET   wr: out_port |= wdata, reads 0
//   5 OUTCLR   wr: out_port &= ~wdata, reads 0
//   6,7        reserved, reads 0
// ---------------------------------------------------------------------------
module pio_gen_edge #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] OUT_RESET = '0,
    parameter logic [WIDTH-1:0] DIR_RESET = '0,
    parameter int               EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_DIR     = 3'd1,
        REG_IRQMASK = 3'd2,
        REG_EDGE    = 3'd3,
        REG_OUTSET  = 3'd4,
        REG_OUTCLR  = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } reg_addr_e;

    reg_addr_e        reg_sel;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wdata;
    logic             wdata_unused;

    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] oe_q,    oe_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] edge_q,  edge_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q,   irq_d;
    logic [WIDTH-1:0] s1_q, s2_q, prev_q;

    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;

    assign reg_sel      = reg_addr_e'(address);
    assign wr           = chipselect & ~write_n;
    assign rd           = chipselect & ~read_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign wdata_unused = ^writedata;

    always_comb begin
        det = '0;
        case (EDGE_TYPE)
            0:       det = s2_q & ~prev_q;
            1:       det = ~s2_q & prev_q;
            default: det = s2_q ^ prev_q;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        clr     = '0;

        if (wr) begin
            case (reg_sel)
                REG_DATA:    out_d  = wdata;
                REG_DIR:     oe_d   = wdata;
                REG_IRQMASK: mask_d = wdata;
                REG_EDGE:    clr    = wdata;
                REG_OUTSET:  out_d  = out_q | wdata;
                REG_OUTCLR:  out_d  = out_q & ~wdata;
                default:     ;
            endcase
        end

        // Capture uses the pre-write direction so a bit switched to output
        // stops capturing at once; a new edge beats a same-cycle clear.
        edge_d = (edge_q & ~clr) | (det & ~oe_q);
        irq_d  = |(edge_q & mask_q);

        // Read mux sees the pre-write register contents.
        if (rd) begin
            rdata_d = '0;
            case (reg_sel)
                REG_DATA:    rdata_d[WIDTH-1:0] = (oe_q & out_q) | (~oe_q & s2_q);
                REG_DIR:     rdata_d[WIDTH-1:0] = oe_q;
                REG_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
                REG_EDGE:    rdata_d[WIDTH-1:0] = edge_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= OUT_RESET;
            oe_q    <= DIR_RESET;
            mask_q  <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            s1_q    <= in_port;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
        end
    end

    assign readdata = rdata_q;
    assign out_port = out_q;
    assign oe       = oe_q;
    assign irq      = irq_q;

endmodule
